// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-stage hazard logic.
// md_state_t encodes the mult/div occupancy FSM; REG_ZERO is the hard-wired
// zero register that never produces a hazard.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int unsigned MULT_LAT_DEF = 4;
  localparam int unsigned DIV_LAT_DEF  = 32;

  // True when a producer writing writeReg feeds a consumer reading srcReg.
  function automatic logic regHit(input logic [4:0] writeReg, input logic [4:0] srcReg);
    return (writeReg != REG_ZERO) && (writeReg == srcReg);
  endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// Mult/div unit occupancy tracker.
// IDLE -> BUSY on start, counts down LAT-1..0 in BUSY, spends exactly one
// cycle in DONE (HI/LO written), then IDLE or straight back to BUSY on a new
// start. A start while BUSY is dropped and latches a sticky error flag.
module md_busy_tracker
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
  parameter int unsigned CNT_W    = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic isDiv_i,
  output logic busy_o,
  output logic done_o,
  output logic err_o
);

  localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_LAT - 1);

  md_state_t        stateQ, stateD;
  logic [CNT_W-1:0] cntQ, cntD;
  logic             errQ, errD;
  logic [CNT_W-1:0] loadVal;

  assign loadVal = isDiv_i ? DivLoad : MultLoad;

  // Next-state, counter and error-flag computation.
  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    errD   = errQ;
    unique case (stateQ)
      IDLE: begin
        if (start_i) begin
          stateD = BUSY;
          cntD   = loadVal;
        end
      end
      BUSY: begin
        // A start here would clobber an in-flight op; drop it and flag.
        if (start_i) begin
          errD = 1'b1;
        end
        if (cntQ != '0) begin
          cntD = cntQ - 1'b1;
        end else begin
          stateD = DONE;
        end
      end
      DONE: begin
        if (start_i) begin
          stateD = BUSY;
          cntD   = loadVal;
        end else begin
          stateD = IDLE;
        end
      end
      default: begin
        stateD = IDLE;
        cntD   = '0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= IDLE;
      cntQ   <= '0;
      errQ   <= 1'b0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      errQ   <= errD;
    end
  end

  // Status outputs decoded from registered state only.
  always_comb begin
    busy_o = (stateQ == BUSY);
    done_o = (stateQ == DONE);
    err_o  = errQ;
  end

endmodule

// File: rtl/stall_ctrl_unit.sv
// Decode-stage hazard detector, companion to the forwarding unit.
// Raises StallF/StallD/FlushE for load-use, branch/jr compare-in-D and
// HI/LO-read-while-busy hazards. Mult/div occupancy lives in md_busy_tracker.
// Optional build macro STALL_PERF_CNT_EN adds wrapping stall perf counters.
module stall_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
  parameter int unsigned CNT_W    = 6
`ifdef STALL_PERF_CNT_EN
  ,
  parameter int unsigned PERF_W   = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic       RegWriteE,
  input  logic       MemtoRegE,
  input  logic       MemtoRegM,
  input  logic       BranchD,
  input  logic       JumpRegD,
  input  logic       MdUseD,
  input  logic       MdStartE,
  input  logic       MdIsDivE,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushE,
  output logic       MdBusy,
  output logic       MdDone,
  output logic       MdErr
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] PerfStallCyc,
  output logic [PERF_W-1:0] PerfLwStall,
  output logic [PERF_W-1:0] PerfMdStall
`endif
);

  logic lwStall;
  logic brStall;
  logic mdStall;
  logic anyStall;
  logic rsHitE, rtHitE, rsHitM, rtHitM;

  md_busy_tracker #(
    .MULT_LAT(MULT_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) uMdTracker (
    .clk    (clk),
    .rst    (rst),
    .start_i(MdStartE),
    .isDiv_i(MdIsDivE),
    .busy_o (MdBusy),
    .done_o (MdDone),
    .err_o  (MdErr)
  );

  // Hazard decode; purely combinational so the stall acts in the same cycle.
  always_comb begin
    rsHitE = regHit(WriteRegE, RsD);
    rtHitE = regHit(WriteRegE, RtD);
    rsHitM = regHit(WriteRegM, RsD);
    rtHitM = regHit(WriteRegM, RtD);

    lwStall = MemtoRegE & RegWriteE & (rsHitE | rtHitE);

    // Compare happens in D, so an ALU result in E or a load result in M
    // cannot be forwarded in time.
    brStall = (BranchD  & ((RegWriteE & (rsHitE | rtHitE)) | (MemtoRegM & (rsHitM | rtHitM))))
            | (JumpRegD & ((RegWriteE & rsHitE) | (MemtoRegM & rsHitM)));

    // A start issuing this cycle will occupy HI/LO too.
    mdStall = MdUseD & (MdBusy | MdStartE);

    anyStall = ~rst & (lwStall | brStall | mdStall);
    StallF   = anyStall;
    StallD   = anyStall;
    FlushE   = anyStall;
  end

`ifdef STALL_PERF_CNT_EN
  logic [PERF_W-1:0] perfStallCycQ, perfLwStallQ, perfMdStallQ;

  // Per-term stall cycle counters; wrap on overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      perfStallCycQ <= '0;
      perfLwStallQ  <= '0;
      perfMdStallQ  <= '0;
    end else begin
      if (lwStall | brStall | mdStall) perfStallCycQ <= perfStallCycQ + 1'b1;
      if (lwStall)                     perfLwStallQ  <= perfLwStallQ + 1'b1;
      if (mdStall)                     perfMdStallQ  <= perfMdStallQ + 1'b1;
    end
  end

  assign PerfStallCyc = perfStallCycQ;
  assign PerfLwStall  = perfLwStallQ;
  assign PerfMdStall  = perfMdStallQ;
`endif

endmodule
